// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; single-cycle logic/arith/compare, serial shifts.
// Optional condition flags (zero/neg/carry/ovf) are built when ALU_EXEC_FLAGS_EN is defined.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'd1
`endif
`ifndef ALU_AND
`define ALU_AND  4'd2
`endif
`ifndef ALU_OR
`define ALU_OR   4'd3
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'd4
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'd5
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'd6
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'd7
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'd8
`endif

module alu_exec_unit #(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ALUSel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
`ifdef ALU_EXEC_FLAGS_EN
  output logic         zero,
  output logic         neg,
  output logic         carry,
  output logic         ovf,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   work_q, work_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;

  logic [N:0]     add_w, sub_w;
  logic [N-1:0]   alu_res, shift1;
  logic [SHW-1:0] shamt;
  logic           is_shift;

  assign shamt    = B[SHW-1:0];
  assign is_shift = (ALUSel == `ALU_SLL) || (ALUSel == `ALU_SRL) || (ALUSel == `ALU_SRA);
  assign add_w    = {1'b0, A} + {1'b0, B};
  // A + ~B + 1: bit N is the inverted borrow.
  assign sub_w    = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    case (ALUSel)
      `ALU_ADD:  alu_res = add_w[N-1:0];
      `ALU_SUB:  alu_res = sub_w[N-1:0];
      `ALU_AND:  alu_res = A & B;
      `ALU_OR:   alu_res = A | B;
      `ALU_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      `ALU_SLTU: alu_res = {{(N-1){1'b0}}, (A < B)};
      `ALU_SLL,
      `ALU_SRL,
      `ALU_SRA:  alu_res = A;  // only reached with shamt == 0
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    shift1 = {work_q[N-2:0], 1'b0};
    if (op_q == `ALU_SRL) begin
      shift1 = {1'b0, work_q[N-1:1]};
    end else if (op_q == `ALU_SRA) begin
      shift1 = {work_q[N-1], work_q[N-1:1]};
    end
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
  logic add_ovf, sub_ovf;

  assign add_ovf = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
  assign sub_ovf = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef ALU_EXEC_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = ALUSel;
          if (is_shift && (shamt != '0)) begin
            work_d  = A;
            cnt_d   = shamt;
            state_d = StShift;
          end else begin
            result_d = alu_res;
            state_d  = StDone;
`ifdef ALU_EXEC_FLAGS_EN
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[N-1];
            carry_d  = (ALUSel == `ALU_ADD) ? add_w[N] :
                       (ALUSel == `ALU_SUB) ? sub_w[N] : 1'b0;
            ovf_d    = (ALUSel == `ALU_ADD) ? add_ovf :
                       (ALUSel == `ALU_SUB) ? sub_ovf : 1'b0;
`endif
          end
        end
      end
      StShift: begin
        work_d = shift1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d = shift1;
          state_d  = StDone;
`ifdef ALU_EXEC_FLAGS_EN
          zero_d   = (shift1 == '0);
          neg_d    = shift1[N-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef ALU_EXEC_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef ALU_EXEC_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
`ifdef ALU_EXEC_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed plan steps followed by random ops against a behavioural model.
// Flag checks are compiled in when ALU_EXEC_FLAGS_EN is defined.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'd1
`endif
`ifndef ALU_AND
`define ALU_AND  4'd2
`endif
`ifndef ALU_OR
`define ALU_OR   4'd3
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'd4
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'd5
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'd6
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'd7
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'd8
`endif

module tb_alu_exec_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]   ALUSel;
  logic [N-1:0] A, B, result;
`ifdef ALU_EXEC_FLAGS_EN
  logic         zero, neg, carry, ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUSel    (ALUSel),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef ALU_EXEC_FLAGS_EN
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_shift_op(input logic [3:0] sel);
    return (sel == `ALU_SLL) || (sel == `ALU_SRL) || (sel == `ALU_SRA);
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (sel)
      `ALU_ADD:  return a + b;
      `ALU_SUB:  return a - b;
      `ALU_AND:  return a & b;
      `ALU_OR:   return a | b;
      `ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      `ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      `ALU_SLL:  return a << sh;
      `ALU_SRL:  return a >> sh;
      `ALU_SRA:  return $signed(a) >>> sh;
      default:   return 32'd0;
    endcase
  endfunction

`ifdef ALU_EXEC_FLAGS_EN
  function automatic logic ref_carry(input logic [3:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
    if (sel == `ALU_ADD) return (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
    if (sel == `ALU_SUB) return a >= b;
    return 1'b0;
  endfunction

  function automatic logic ref_ovf(input logic [3:0] sel, input logic [31:0] a,
                                   input logic [31:0] b);
    longint s;
    if (sel == `ALU_ADD) s = longint'($signed(a)) + longint'($signed(b));
    else if (sel == `ALU_SUB) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction
`endif

  // One full transaction: accept, wait for result, optional backpressure, handoff.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int          lat, exp_lat;
    logic [31:0] exp_r, held;
    exp_r   = ref_result(sel, a, b);
    exp_lat = (is_shift_op(sel) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    ALUSel    = sel;
    A         = a;
    B         = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUSel   = 4'($urandom);
    A        = $urandom;
    B        = $urandom;
    lat      = 1;
    while (!out_valid && lat <= N + 2) begin
      check("in_ready_shift", 64'(in_ready), 64'd0);
      check("busy_shift", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid", 64'(out_valid), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(result), 64'(exp_r));
    check("busy_done", 64'(busy), 64'd1);
`ifdef ALU_EXEC_FLAGS_EN
    check("zero", 64'(zero), 64'(exp_r == 32'd0));
    check("neg", 64'(neg), 64'(exp_r[31]));
    check("carry", 64'(carry), 64'(ref_carry(sel, a, b)));
    check("ovf", 64'(ovf), 64'(ref_ovf(sel, a, b)));
`endif
    held = exp_r;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ALUSel   = 4'($urandom);
      A        = $urandom;
      B        = $urandom;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_valid", 64'(out_valid), 64'd0);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
    check("handoff_busy", 64'(busy), 64'd0);
    check("handoff_result", 64'(result), 64'(held));
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef ALU_EXEC_FLAGS_EN
    check({tag, "_flags"}, 64'({zero, neg, carry, ovf}), 64'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUSel    = '0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset("rst_held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_reset("rst_after");

    run_op(`ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(`ALU_SUB, 32'd5, 32'd7, 0);
    run_op(`ALU_SLT, 32'd5, 32'd7, 0);
    run_op(`ALU_SLTU, 32'd5, 32'd7, 0);
    run_op(`ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(`ALU_SRA, 32'h8000_0000, 32'd31, 0);
    run_op(`ALU_SLL, 32'h1234_5678, 32'd0, 0);
    run_op(`ALU_ADD, 32'd10, 32'd20, 5);

    // Abort an SLL by 20 with reset on its third cycle.
    @(negedge clk);
    in_valid = 1'b1;
    ALUSel   = `ALU_SLL;
    A        = 32'hDEAD_BEEF;
    B        = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_result", 64'(out_valid), 64'd0);
    end
    run_op(`ALU_OR, 32'h0000_00F0, 32'h0000_000F, 0);
    run_op(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    for (int k = 0; k < 60; k++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
